// File: rtl/avalon_io_adapter.sv
// Avalon-MM slave to single-cycle I/O bridge adapter with a fixed read latency.
// Define AVIO_POSTED_WR_EN to complete Avalon writes in their acceptance cycle.
module avalon_io_adapter #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        io_rw,
    output logic [3:0]  io_byte_enable,
    output logic [29:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wait_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 30'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                // A simultaneous read and write is serviced as a write.
                if (avs_write) begin
                    addr_d  = avs_address;
                    be_d    = avs_byteenable;
                    wdata_d = avs_writedata;
                    state_d = WRITE;
`ifdef AVIO_POSTED_WR_EN
                    wait_d  = 1'b0;
`endif
                end else if (avs_read) begin
                    addr_d  = avs_address;
                    be_d    = avs_byteenable;
                    cnt_d   = 4'(READ_LAT);
                    state_d = READ_WAIT;
                end
            end
            WRITE: begin
`ifndef AVIO_POSTED_WR_EN
                wait_d  = 1'b0;
`endif
                state_d = IDLE;
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = io_read_data;
                    state_d = READ_DONE;
                end
            end
            READ_DONE: begin
                wait_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign avs_waitrequest = wait_d | ~reset_n;
    assign avs_readdata    = rdata_q;
    assign io_rw           = (state_q == WRITE);
    assign io_address      = addr_q;
    assign io_byte_enable  = be_q;
    assign io_write_data   = wdata_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_avalon_io_adapter.sv
// Directed bench for avalon_io_adapter with READ_LAT=3.
// Expectations follow AVIO_POSTED_WR_EN when it is defined for the build.
module tb_avalon_io_adapter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] avs_address;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        io_rw;
    logic [3:0]  io_byte_enable;
    logic [29:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_io_adapter #(.READ_LAT(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_byteenable (avs_byteenable),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .io_rw          (io_rw),
        .io_byte_enable (io_byte_enable),
        .io_address     (io_address),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus_idle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic drive_wr(input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
    endtask

    logic rw_seen [0:4];

    initial begin
        reset_n        = 1'b0;
        avs_address    = '0;
        avs_byteenable = '0;
        avs_writedata  = '0;
        io_read_data   = '0;
        bus_idle();

        // Reset state
        tick(); tick(); settle();
        check("rst_wait",  32'(avs_waitrequest), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rw",    32'(io_rw), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_addr",  32'(io_address), 32'd0);
        check("rst_wdata", io_write_data, 32'd0);
        check("rst_be",    32'(io_byte_enable), 32'd0);
        tick(); reset_n = 1'b1; settle();

        // Single write 0x10 / DEADBEEF / F
        tick(); drive_wr(30'h10, 32'hDEAD_BEEF, 4'hF); settle();
`ifdef AVIO_POSTED_WR_EN
        check("wr_acc_wait", 32'(avs_waitrequest), 32'd0);
`else
        check("wr_acc_wait", 32'(avs_waitrequest), 32'd1);
`endif
        check("wr_acc_rw", 32'(io_rw), 32'd0);
        tick();
`ifdef AVIO_POSTED_WR_EN
        bus_idle();
`endif
        settle();
        check("wr_rw",    32'(io_rw), 32'd1);
        check("wr_addr",  32'(io_address), 32'h10);
        check("wr_data",  io_write_data, 32'hDEAD_BEEF);
        check("wr_be",    32'(io_byte_enable), 32'hF);
        check("wr_busy",  32'(busy), 32'd1);
`ifdef AVIO_POSTED_WR_EN
        check("wr_wait",  32'(avs_waitrequest), 32'd1);
`else
        check("wr_wait",  32'(avs_waitrequest), 32'd0);
`endif
        tick(); bus_idle(); settle();
        check("wr_end_rw",   32'(io_rw), 32'd0);
        check("wr_end_busy", 32'(busy), 32'd0);
        check("wr_end_wait", 32'(avs_waitrequest), 32'd1);
        check("wr_hold_addr", 32'(io_address), 32'h10);

        // Read 0x200004; the bridge data is valid only in the sampling cycle
        tick();
        avs_read       = 1'b1;
        avs_address    = 30'h0020_0004;
        avs_byteenable = 4'hF;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            io_read_data = (k == 3) ? 32'h1234_5678 : (32'hBAD0_0000 | k);
            settle();
            check($sformatf("rd_wait_c%0d", k), 32'(avs_waitrequest),
                  (k == 4) ? 32'd0 : 32'd1);
            check($sformatf("rd_rw_c%0d", k), 32'(io_rw), 32'd0);
        end
        check("rd_data", avs_readdata, 32'h1234_5678);
        check("rd_addr", 32'(io_address), 32'h0020_0004);
        tick(); bus_idle(); io_read_data = 32'hFFFF_FFFF; settle();
        check("rd_end_busy", 32'(busy), 32'd0);
        check("rd_hold",     avs_readdata, 32'h1234_5678);

        // Read and write together: serviced as a write
        tick();
        drive_wr(30'h30, 32'hCAFE_0001, 4'h3);
        avs_read = 1'b1;
        settle();
`ifdef AVIO_POSTED_WR_EN
        check("rw_acc_wait", 32'(avs_waitrequest), 32'd0);
        tick(); bus_idle();
`else
        check("rw_acc_wait", 32'(avs_waitrequest), 32'd1);
        tick();
`endif
        settle();
        check("rw_rw",   32'(io_rw), 32'd1);
        check("rw_addr", 32'(io_address), 32'h30);
        check("rw_data", io_write_data, 32'hCAFE_0001);
        check("rw_be",   32'(io_byte_enable), 32'h3);
        tick(); bus_idle(); settle();
        check("rw_rdata", avs_readdata, 32'h1234_5678);
        check("rw_busy",  32'(busy), 32'd0);

        // Back-to-back writes 0x4 then 0x8
        for (int k = 0; k <= 4; k++) begin
            if (k > 0 || 1'b1) tick();
`ifdef AVIO_POSTED_WR_EN
            if (k == 0) drive_wr(30'h4, 32'h1111_1111, 4'hF);
            else if (k <= 2) drive_wr(30'h8, 32'h2222_2222, 4'hF);
            else bus_idle();
`else
            if (k <= 1) drive_wr(30'h4, 32'h1111_1111, 4'hF);
            else if (k <= 3) drive_wr(30'h8, 32'h2222_2222, 4'hF);
            else bus_idle();
`endif
            settle();
            rw_seen[k] = io_rw;
`ifdef AVIO_POSTED_WR_EN
            if (k <= 2)
                check($sformatf("b2b_wait_c%0d", k), 32'(avs_waitrequest),
                      (k == 1) ? 32'd1 : 32'd0);
`else
            if (k <= 3)
                check($sformatf("b2b_wait_c%0d", k), 32'(avs_waitrequest),
                      (k == 1 || k == 3) ? 32'd0 : 32'd1);
`endif
            if (k == 1) check("b2b_addr1", 32'(io_address), 32'h4);
            if (k == 3) check("b2b_addr2", 32'(io_address), 32'h8);
            if (k == 3) check("b2b_data2", io_write_data, 32'h2222_2222);
        end
        for (int k = 0; k <= 4; k++)
            check($sformatf("b2b_rw_c%0d", k), 32'(rw_seen[k]),
                  (k == 1 || k == 3) ? 32'd1 : 32'd0);

        // Reset during READ_WAIT aborts the read
        tick();
        avs_read     = 1'b1;
        avs_address  = 30'h40;
        io_read_data = 32'h55AA_55AA;
        settle();
        tick(); settle();
        check("ab_busy_rw", 32'(busy), 32'd1);
        tick(); bus_idle(); reset_n = 1'b0; settle();
        check("ab_rst_wait", 32'(avs_waitrequest), 32'd1);
        tick(); reset_n = 1'b1; settle();
        check("ab_busy",  32'(busy), 32'd0);
        check("ab_rdata", avs_readdata, 32'd0);
        check("ab_rw",    32'(io_rw), 32'd0);
        check("ab_addr",  32'(io_address), 32'd0);
        tick(); settle();
        check("ab_idle_rdata", avs_readdata, 32'd0);

        // Following read completes normally, bounded wait
        tick();
        avs_read     = 1'b1;
        avs_address  = 30'h44;
        io_read_data = 32'h0BAD_F00D;
        settle();
        begin
            int lat;
            lat = -1;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) begin
                    tick(); settle();
                end
                if (lat < 0 && !avs_waitrequest) lat = k;
            end
            check("ab_rd_lat", 32'(lat), 32'd4);
        end
        check("ab_rd_data", avs_readdata, 32'h0BAD_F00D);
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_io_adapter.md
AVALON_IO_ADAPTER -- requirements
Module: avalon_io_adapter

Interface
REQ-001 The block SHALL have one parameter: READ_LAT, default 1, the number of clk cycles from io_address becoming valid to io_read_data being sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port avs_address, input, 30 bits: Avalon word address.
REQ-005 The block SHALL have port avs_byteenable, input, 4 bits: Avalon byte enables.
REQ-006 The block SHALL have port avs_read, input, 1 bit: Avalon read request.
REQ-007 The block SHALL have port avs_write, input, 1 bit: Avalon write request.
REQ-008 The block SHALL have port avs_writedata, input, 32 bits: Avalon write data.
REQ-009 The block SHALL have port avs_readdata, output, 32 bits: registered read data.
REQ-010 The block SHALL have port avs_waitrequest, output, 1 bit: Avalon stall; a transfer completes in the cycle where the request is high and waitrequest is low.
REQ-011 The block SHALL have ports io_rw (output, 1), io_byte_enable (output, 4), io_address (output, 30), io_write_data (output, 32) and io_read_data (input, 32), connecting to the downstream I/O bridge.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, WRITE, READ_WAIT and READ_DONE.
REQ-014 In IDLE with avs_write=1, it SHALL latch avs_address, avs_byteenable and avs_writedata into io_address, io_byte_enable and io_write_data, then go to WRITE.
REQ-015 In WRITE, io_rw SHALL be 1 for exactly one cycle; the next state SHALL be IDLE. At all other times io_rw SHALL be 0.
REQ-016 In IDLE with avs_read=1 and avs_write=0, it SHALL latch avs_address and avs_byteenable, load the latency counter with READ_LAT, then go to READ_WAIT.
REQ-017 In READ_WAIT, the counter SHALL decrement once per cycle.
REQ-018 When the counter equals 1 in READ_WAIT, io_read_data SHALL be registered into avs_readdata and the next state SHALL be READ_DONE. Total time from acceptance to READ_DONE is therefore READ_LAT+1 cycles.
REQ-019 In READ_DONE, avs_waitrequest SHALL be 0, completing the read; the next state SHALL be IDLE.
REQ-020 When avs_read and avs_write are both 1 in IDLE, the request SHALL be treated as a write.
REQ-021 io_address, io_byte_enable, io_write_data and avs_readdata SHALL hold their values until the next accepted transfer reloads them.
REQ-022 Avalon inputs SHALL be ignored in every state except IDLE.
REQ-023 A new request present in the cycle the block returns to IDLE SHALL be accepted in that IDLE cycle; there SHALL be no additional idle gap.

Reset
REQ-024 While reset_n=0 at a clk edge, the state SHALL become IDLE, the counter 0, io_rw 0, io_address 0, io_byte_enable 0, io_write_data 0 and avs_readdata 0.
REQ-025 avs_waitrequest SHALL be 1 while reset_n=0.
REQ-026 A reset asserted mid-transaction SHALL abort it, with no io_rw pulse and no readdata update in the following cycle.

Configuration
REQ-027 The macro AVIO_POSTED_WR_EN SHALL select posted writes.
REQ-028 With AVIO_POSTED_WR_EN defined, avs_waitrequest SHALL be 0 in the IDLE acceptance cycle of a write, so the Avalon write completes in one cycle while the WRITE state still pulses io_rw in the next cycle.
REQ-029 With AVIO_POSTED_WR_EN undefined, avs_waitrequest SHALL be 1 in IDLE and 0 in WRITE, so a write takes two cycles.
REQ-030 avs_waitrequest SHALL be 1 in every state and condition not covered by REQ-019, REQ-028 or REQ-029.

Verification
REQ-031 The bench SHALL cover a non-posted write: addr=0x0000_0010, data=0xDEAD_BEEF, be=0xF -> io_rw=1 for one cycle with those values on the io_* ports; waitrequest low only in that cycle; avs_write held for 2 cycles.
REQ-032 The bench SHALL cover a read with READ_LAT=3: addr=0x0020_0004 and io_read_data=0x1234_5678 -> waitrequest low exactly 4 cycles after acceptance; avs_readdata=0x1234_5678; io_rw=0 throughout.
REQ-033 The bench SHALL cover avs_read=1 and avs_write=1 together in IDLE -> a write is performed; io_read_data is never sampled.
REQ-034 The bench SHALL cover back-to-back writes to 0x4 then 0x8 with AVIO_POSTED_WR_EN defined -> the first completes in 1 cycle, the second is stalled 1 cycle, and two io_rw pulses appear 2 cycles apart.
REQ-035 The bench SHALL cover reset_n=0 during READ_WAIT -> next cycle is IDLE, avs_readdata=0, busy=0, and the following read completes normally.
